// File: rtl/mul_rr_sched.sv
// Round-robin scheduler that shares one registered unsigned multiplier among NREQ
// requesters, returning each product tagged with the owning requester's index.
module mul_rr_sched #(
  parameter int NREQ   = 4,
  parameter int LENin1 = 8,
  parameter int LENin2 = 8,
  parameter int LENres = 2 * ((LENin1 > LENin2) ? LENin1 : LENin2),
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*LENin1-1:0]   req_a,
  input  logic [NREQ*LENin2-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  output logic [LENres-1:0]        res_data,
  output logic [IDW-1:0]           res_id,
  input  logic                     res_ready
);

  localparam int PW = (LENres > LENin1 + LENin2) ? LENres : (LENin1 + LENin2);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_res_id;
  logic [LENin1-1:0] r_a;
  logic [LENin2-1:0] r_b;
  logic [LENres-1:0] r_res;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_gnt_found;
  logic [PW-1:0]     w_prod;
  int                w_idx;

  // Search starts at the round-robin pointer and wraps; the first active requester wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = IDW'(w_idx);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_next = S_MUL;
          if (nrst) req_ready = NREQ'(1) << w_gnt_id;
        end
      end
      S_MUL:   w_next = S_OUT;
      S_OUT:   if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_prod = PW'(r_a) * PW'(r_b);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_res_id <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_gnt_found) begin
        r_a      <= req_a[int'(w_gnt_id) * LENin1 +: LENin1];
        r_b      <= req_b[int'(w_gnt_id) * LENin2 +: LENin2];
        r_id     <= w_gnt_id;
        r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
      end
      // Result and tag only change while the result port is idle, so they never glitch in OUT.
      if (r_state == S_MUL) begin
        r_res    <= w_prod[LENres-1:0];
        r_res_id <= r_id;
      end
    end
  end

  assign res_valid = (r_state == S_OUT);
  assign res_data  = r_res;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Directed bench for mul_rr_sched: reset, single request, round robin,
// back-pressure, operand extremes and reset during a multiply.
module tb_mul_rr_sched;

  logic        clk;
  logic        nrst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;

  int checks = 0;
  int errors = 0;

  mul_rr_sched #(.NREQ(4), .LENin1(8), .LENin2(8)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full clock: through the active edge, then to the sampling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0]  idTab [6];
  logic [15:0] prodTab [4];

  initial begin
    idTab   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    prodTab = '{16'h0010, 16'h0040, 16'h0090, 16'h0100};

    nrst      = 1'b0;
    req_valid = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    res_ready = 1'($urandom);
    @(negedge clk);
    tick();
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
    checkOutput("reset_res_data",  32'(res_data),  32'h0);
    checkOutput("reset_res_id",    32'(res_id),    32'h0);

    $display("[TB] single request");
    req_valid = 4'b0100;
    req_a     = 32'h000F_0000;
    req_b     = 32'h0011_0000;
    res_ready = 1'b1;
    nrst      = 1'b1;
    #1;
    checkOutput("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checkOutput("single_mul_ready", 32'(req_ready), 32'h0);
    checkOutput("single_mul_valid", 32'(res_valid), 32'h0);
    tick();
    checkOutput("single_res_valid", 32'(res_valid), 32'h1);
    checkOutput("single_res_data",  32'(res_data),  32'h00FF);
    checkOutput("single_res_id",    32'(res_id),    32'h2);
    tick();
    checkOutput("single_accepted", 32'(res_valid), 32'h0);

    $display("[TB] round robin");
    nrst = 1'b0;
    @(negedge clk);
    nrst      = 1'b1;
    req_valid = 4'b1111;
    req_a     = 32'h0403_0201;
    req_b     = 32'h4030_2010;
    res_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      checkOutput($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(4'b0001 << idTab[n]));
      tick();
      checkOutput($sformatf("rr_mul_ready%0d", n), 32'(req_ready), 32'h0);
      tick();
      checkOutput($sformatf("rr_valid%0d", n), 32'(res_valid), 32'h1);
      checkOutput($sformatf("rr_id%0d", n),    32'(res_id),    32'(idTab[n]));
      checkOutput($sformatf("rr_data%0d", n),  32'(res_data),  32'(prodTab[idTab[n]]));
      tick();
    end

    $display("[TB] back-pressure with max operands");
    req_a     = 32'h00FF_0000;
    req_b     = 32'hFFFF_0000;
    res_ready = 1'b0;
    #1;
    checkOutput("bp_grant", 32'(req_ready), 32'h4);
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("bp_valid%0d", n), 32'(res_valid), 32'h1);
      checkOutput($sformatf("bp_data%0d", n),  32'(res_data),  32'hFE01);
      checkOutput($sformatf("bp_id%0d", n),    32'(res_id),    32'h2);
      checkOutput($sformatf("bp_ready%0d", n), 32'(req_ready), 32'h0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", 32'(res_valid), 32'h0);
    checkOutput("bp_next_grant",    32'(req_ready), 32'h8);
    tick();
    tick();
    checkOutput("zero_valid", 32'(res_valid), 32'h1);
    checkOutput("zero_data",  32'(res_data),  32'h0000);
    checkOutput("zero_id",    32'(res_id),    32'h3);
    req_valid = 4'b0000;
    tick();
    checkOutput("zero_accepted", 32'(res_valid), 32'h0);

    $display("[TB] reset during multiply");
    req_valid = 4'b0100;
    req_a     = 32'h0033_0000;
    req_b     = 32'h0044_0000;
    #1;
    checkOutput("rst_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    nrst      = 1'b0;
    #1;
    checkOutput("rst_low_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_low_valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput($sformatf("rst_no_result%0d", n), 32'(res_valid), 32'h0);
    end
    req_valid = 4'b1010;
    #1;
    checkOutput("rst_ptr_grant", 32'(req_ready), 32'h2);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
